// File: rtl/final_adder_pipe_if.sv
// Handshake bundle between the compressor tree, final_adder_pipe and the result consumer.
// The cout member exists only when FINAL_ADDER_CARRY_OUT_EN is defined.
interface final_adder_pipe_if #(
  parameter int unsigned PROD_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] sum;
  logic [PROD_W-1:0] carry;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] product;
`ifdef FINAL_ADDER_CARRY_OUT_EN
  logic              cout;

  modport master (
    output in_valid, sum, carry, out_ready,
    input  in_ready, out_valid, product, cout
  );
  modport slave (
    input  in_valid, sum, carry, out_ready,
    output in_ready, out_valid, product, cout
  );
`else
  modport master (
    output in_valid, sum, carry, out_ready,
    input  in_ready, out_valid, product
  );
  modport slave (
    input  in_valid, sum, carry, out_ready,
    output in_ready, out_valid, product
  );
`endif
endinterface

// File: rtl/final_adder_pipe.sv
// Segmented pipelined carry-propagate adder: product = (sum + carry) mod 2^PROD_W, one SEG_W segment per stage.
// Optional FINAL_ADDER_CARRY_OUT_EN exposes the top-segment carry-out as cout.
module final_adder_pipe #(
  parameter int unsigned W      = 16,
  parameter int unsigned PROD_W = 2 * W,
  parameter int unsigned SEG_W  = 8
) (
  input logic               clk,
  input logic               rst,
  final_adder_pipe_if.slave bus
);

  localparam int unsigned NUM_SEG = (PROD_W + SEG_W - 1) / SEG_W;
  localparam int unsigned LAST_W  = PROD_W - (NUM_SEG - 1) * SEG_W;

  typedef logic [PROD_W-1:0] word_t;
  typedef logic [PROD_W:0]   ext_t;

  logic  adv;

  logic  v_q   [NUM_SEG];
  word_t s_q   [NUM_SEG];
  word_t c_q   [NUM_SEG];
  logic  cy_q  [NUM_SEG];

  logic  v_pre  [NUM_SEG];
  word_t s_pre  [NUM_SEG];
  word_t c_pre  [NUM_SEG];
  logic  cy_pre [NUM_SEG];

  word_t s_d  [NUM_SEG];
  logic  cy_d [NUM_SEG];

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign adv          = !v_q[NUM_SEG-1] || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin : stage_inputs
    for (int unsigned k = 0; k < NUM_SEG; k++) begin
      v_pre[k]  = 1'b0;
      s_pre[k]  = '0;
      c_pre[k]  = '0;
      cy_pre[k] = 1'b0;
    end
    v_pre[0]  = bus.in_valid;
    s_pre[0]  = bus.sum;
    c_pre[0]  = bus.carry;
    cy_pre[0] = 1'b0;
    for (int unsigned k = 1; k < NUM_SEG; k++) begin
      v_pre[k]  = v_q[k-1];
      s_pre[k]  = s_q[k-1];
      c_pre[k]  = c_q[k-1];
      cy_pre[k] = cy_q[k-1];
    end
  end

  // s_q[k] carries resolved bits below and including segment k, raw sum bits above it.
  always_comb begin : segment_add
    ext_t        s_ext, c_ext, mask, t, res;
    int unsigned lo, wid;
    s_ext = '0;
    c_ext = '0;
    mask  = '0;
    t     = '0;
    res   = '0;
    lo    = 0;
    wid   = 0;
    for (int unsigned k = 0; k < NUM_SEG; k++) begin
      s_d[k]  = '0;
      cy_d[k] = 1'b0;
    end
    for (int unsigned k = 0; k < NUM_SEG; k++) begin
      s_ext   = {1'b0, s_pre[k]};
      c_ext   = {1'b0, c_pre[k]};
      lo      = k * SEG_W;
      wid     = (k == NUM_SEG - 1) ? LAST_W : SEG_W;
      mask    = ~({(PROD_W + 1){1'b1}} << wid);
      t       = ((s_ext >> lo) & mask) + ((c_ext >> lo) & mask) + ext_t'(cy_pre[k]);
      res     = (s_ext & ~(mask << lo)) | ((t & mask) << lo);
      s_d[k]  = word_t'(res);
      cy_d[k] = |((t >> wid) & ext_t'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_SEG; k++) begin
        v_q[k]  <= 1'b0;
        s_q[k]  <= '0;
        c_q[k]  <= '0;
        cy_q[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < NUM_SEG; k++) begin
        v_q[k]  <= v_pre[k];
        s_q[k]  <= s_d[k];
        c_q[k]  <= c_pre[k];
        cy_q[k] <= cy_d[k];
      end
    end
  end

  assign bus.out_valid = v_q[NUM_SEG-1];
  assign bus.product   = s_q[NUM_SEG-1];
`ifdef FINAL_ADDER_CARRY_OUT_EN
  assign bus.cout      = cy_q[NUM_SEG-1];
`endif

endmodule

// File: tb/tb_final_adder_pipe.sv
// Bench for final_adder_pipe: three instances (SEG_W 4, 5, 16; PROD_W 16) share stimulus,
// each checked every cycle against a queue of (sum+carry) sums, plus directed literal checks on SEG_W=4.
module tb_final_adder_pipe;

  localparam int unsigned PW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [PW-1:0] sum;
  logic [PW-1:0] carry;

  logic [2:0]    ov;
  logic [2:0]    ir;
  logic [2:0]    co;
  logic [PW-1:0] prod [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int unsigned SEG = (i == 0) ? 4 : ((i == 1) ? 5 : 16);

    final_adder_pipe_if #(.PROD_W(PW)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.sum       = sum;
    assign bus.carry     = carry;
    assign bus.out_ready = out_ready;
    assign ov[i]         = bus.out_valid;
    assign ir[i]         = bus.in_ready;
    assign prod[i]       = bus.product;
`ifdef FINAL_ADDER_CARRY_OUT_EN
    assign co[i]         = bus.cout;
`else
    assign co[i]         = 1'b0;
`endif

    final_adder_pipe #(.W(8), .PROD_W(PW), .SEG_W(SEG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    // Expected full sums (with carry-out) of accepted inputs, oldest first.
    logic [PW:0] q[$];

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else begin
        check($sformatf("d%0d_in_ready", i), 32'(ir[i]), 32'(!ov[i] || out_ready));
        if (ov[i]) begin
          check($sformatf("d%0d_pending", i), 32'(q.size() != 0), 32'(1));
          if (q.size() != 0) begin
            check($sformatf("d%0d_product", i), 32'(prod[i]), 32'(q[0][PW-1:0]));
`ifdef FINAL_ADDER_CARRY_OUT_EN
            check($sformatf("d%0d_cout", i), 32'(co[i]), 32'(q[0][PW]));
`endif
            if (out_ready) void'(q.pop_front());
          end
        end
        if (in_valid && ir[i]) q.push_back(17'(sum) + 17'(carry));
      end
    end
  end

  // Timing log for the SEG_W=4 instance: consumed outputs and accept cycles.
  logic [PW:0] obs[$];
  int          obs_c[$];
  int          acc_c[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (ov[0] && out_ready) begin
        obs.push_back({co[0], prod[0]});
        obs_c.push_back(cyc);
      end
      if (in_valid && ir[0]) acc_c.push_back(cyc);
    end
  end

  function automatic logic [PW:0] obs_at(input int k);
    if (k < obs.size()) return obs[k];
    return 'x;
  endfunction

  function automatic int lat_at(input int k);
    if (k < obs_c.size() && k < acc_c.size()) return obs_c[k] - acc_c[k];
    return -1;
  endfunction

  function automatic int gap_at(input int k);
    if (k < obs_c.size()) return obs_c[k] - obs_c[0];
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic clear_logs();
    obs.delete();
    obs_c.delete();
    acc_c.delete();
  endtask

  task automatic drive(input logic [PW-1:0] s, input logic [PW-1:0] c);
    in_valid = 1'b1;
    sum      = s;
    carry    = c;
    step();
    in_valid = 1'b0;
  endtask

`ifdef FINAL_ADDER_CARRY_OUT_EN
  localparam logic [PW:0] RIPPLE_EXP = 17'h1_0000;
`else
  localparam logic [PW:0] RIPPLE_EXP = 17'h0_0000;
`endif

  logic [PW-1:0] b2b_exp [8] = '{16'h0F0F, 16'h2020, 16'h3131, 16'h4242,
                                 16'h5353, 16'h6464, 16'h7575, 16'h8686};
  int            bub_off [3] = '{4, 6, 9};
  logic          bub_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int acc0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sum = '0; carry = '0;
    repeat (2) step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("d%0d_reset_out_valid", i), 32'(ov[i]), 32'(0));
      check($sformatf("d%0d_reset_product", i), 32'(prod[i]), 32'(0));
      check($sformatf("d%0d_reset_in_ready", i), 32'(ir[i]), 32'(1));
    end
    rst = 1'b0;

    // Full carry ripple through every segment
    clear_logs();
    drive(16'hFFFF, 16'h0001);
    idle(8);
    check("ripple_count", 32'(obs.size()), 32'(1));
    check("ripple_product", 32'(obs_at(0)), 32'(RIPPLE_EXP));
    check("ripple_latency", 32'(lat_at(0)), 32'(4));

    // Back-to-back stream
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      sum      = 16'(i) * 16'h1111;
      carry    = 16'h0F0F;
      step();
    end
    idle(8);
    check("b2b_count", 32'(obs.size()), 32'(8));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b_product_%0d", i), 32'(obs_at(i) & 17'h0FFFF), 32'(b2b_exp[i]));
      check($sformatf("b2b_latency_%0d", i), 32'(lat_at(i)), 32'(4));
      check($sformatf("b2b_gap_%0d", i), 32'(gap_at(i)), 32'(i));
    end

    // Stall with a full pipe
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      sum      = 16'hA000 + 16'(i) * 16'h0123;
      carry    = 16'h6111;
      step();
    end
    check("stall_front_valid", 32'(ov[0]), 32'(1));
    check("stall_front_product", 32'(prod[0]), 32'(16'h0111));
    out_ready = 1'b0;
    sum       = 16'hA000 + 16'd4 * 16'h0123;
    #1;
    check("stall_in_ready", 32'(ir[0]), 32'(0));
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("stall_in_ready_%0d", i), 32'(ir[0]), 32'(0));
      check($sformatf("stall_out_valid_%0d", i), 32'(ov[0]), 32'(1));
      check($sformatf("stall_product_%0d", i), 32'(prod[0]), 32'(16'h0111));
    end
    out_ready = 1'b1;
    k = 4;
    for (int g = 0; g < 20 && k < 6; g++) begin
      in_valid = 1'b1;
      sum      = 16'hA000 + 16'(k) * 16'h0123;
      carry    = 16'h6111;
      #1;
      if (ir[0]) k++;
      step();
    end
    idle(10);
    check("stall_count", 32'(obs.size()), 32'(6));
    for (int i = 0; i < 6; i++)
      check($sformatf("stall_order_%0d", i), 32'(obs_at(i) & 17'h0FFFF),
            32'((16'hA000 + 16'(i) * 16'h0123 + 16'h6111) & 16'hFFFF));

    // Bubbles keep their spacing
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      in_valid = bub_pat[i];
      sum      = 16'(i) * 16'h0100;
      carry    = 16'h0001;
      step();
    end
    idle(8);
    check("bubble_count", 32'(obs.size()), 32'(3));
    for (int i = 0; i < 3; i++)
      check($sformatf("bubble_offset_%0d", i),
            32'((i < obs_c.size() && acc_c.size() > 0) ? obs_c[i] - acc_c[0] : -1),
            32'(bub_off[i]));

    // Reset with data in flight
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      sum      = 16'(i) * 16'h1111 + 16'h0001;
      carry    = 16'h0002;
      step();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    idle(6);
    check("rst_flush_count", 32'(obs.size()), 32'(0));
    clear_logs();
    drive(16'h1234, 16'h4321);
    idle(6);
    check("rst_next_count", 32'(obs.size()), 32'(1));
    check("rst_next_product", 32'(obs_at(0) & 17'h0FFFF), 32'(16'h5555));

    // Random traffic with random backpressure on all three instances
    acc0 = 0;
    for (int g = 0; g < 6000 && acc0 < 1000; g++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      sum       = 16'($urandom);
      carry     = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && ir[0]) acc0++;
      step();
    end
    check("rand_accepted", 32'(acc0), 32'(1000));
    out_ready = 1'b1;
    idle(30);
    check("d0_drained", 32'(g_dut[0].q.size()), 32'(0));
    check("d1_drained", 32'(g_dut[1].q.size()), 32'(0));
    check("d2_drained", 32'(g_dut[2].q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
